vec_cache_wdb_fill: RTL and testbench

VEC_CACHE_WDB_FILL -- requirements
Module: vec_cache_wdb_fill

---
 rtl/vec_cache_wdb_fill.sv | 144 ++++++++++++++
 tb/tb_vec_cache_wdb_fill.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cache_wdb_fill.sv
// Gathers BEATS write-data beats into one WDB line and writes it to a pre-allocated entry.
// The first beat and its WDB entry are accepted together; a last/count mismatch is flagged but still written.
module vec_cache_wdb_fill #(
    parameter int BEAT_WIDTH      = 256,
    parameter int LINE_WIDTH      = 1024,
    parameter int ENTRY_IDX_WIDTH = 5,
    parameter int TXN_ID_WIDTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [BEAT_WIDTH-1:0]      in_data,
    input  logic                       in_last,
    input  logic [TXN_ID_WIDTH-1:0]    in_txn_id,
    input  logic                       alloc_vld,
    output logic                       alloc_rdy,
    input  logic [ENTRY_IDX_WIDTH-1:0] alloc_idx,
    output logic                       wdb_vld,
    input  logic                       wdb_rdy,
    output logic [ENTRY_IDX_WIDTH-1:0] wdb_entry_id,
    output logic [LINE_WIDTH-1:0]      wdb_data,
    output logic                       done_vld,
    output logic [ENTRY_IDX_WIDTH-1:0] done_entry_id,
    output logic [TXN_ID_WIDTH-1:0]    done_txn_id,
    output logic                       err_pulse
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]                 state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [LINE_WIDTH-1:0]      line_reg, line_next;
    logic [ENTRY_IDX_WIDTH-1:0] entry_reg;
    logic [TXN_ID_WIDTH-1:0]    txn_reg;
    logic                       done_vld_reg;
    logic [ENTRY_IDX_WIDTH-1:0] done_entry_reg;
    logic [TXN_ID_WIDTH-1:0]    done_txn_reg;
    logic                       err_reg;

    logic first_beat;
    logic beat_acc;
    logic at_last_beat;
    logic final_beat;
    logic len_err;
    logic wdb_fire;

    assign first_beat   = (state_reg == IDLE) && in_vld && alloc_vld;
    assign beat_acc     = first_beat || ((state_reg == FILL) && in_vld);
    assign at_last_beat = (cnt_reg == LAST_BEAT);
    assign final_beat   = beat_acc && (in_last || at_last_beat);
    assign len_err      = beat_acc && (in_last != at_last_beat);
    assign wdb_fire     = (state_reg == WRITE) && wdb_rdy;

    // Ready terms are gated by rst_n so both read 0 while reset is held.
    assign in_rdy    = rst_n && (((state_reg == IDLE) && alloc_vld) || (state_reg == FILL));
    assign alloc_rdy = rst_n && (state_reg == IDLE) && in_vld;

    assign wdb_vld       = (state_reg == WRITE);
    assign wdb_entry_id  = entry_reg;
    assign wdb_data      = line_reg;
    assign done_vld      = done_vld_reg;
    assign done_entry_id = done_entry_reg;
    assign done_txn_id   = done_txn_reg;
    assign err_pulse     = err_reg;

    // A first beat clears every slot it does not write, so short lines stay zero-padded.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            always_comb begin
                if (beat_acc && (cnt_reg == CNT_W'(gi))) begin
                    line_next[gi*BEAT_WIDTH +: BEAT_WIDTH] = in_data;
                end else if (first_beat) begin
                    line_next[gi*BEAT_WIDTH +: BEAT_WIDTH] = '0;
                end else begin
                    line_next[gi*BEAT_WIDTH +: BEAT_WIDTH] = line_reg[gi*BEAT_WIDTH +: BEAT_WIDTH];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE, FILL: begin
                if (beat_acc) begin
                    if (final_beat) begin
                        state_next = WRITE;
                    end else begin
                        state_next = FILL;
                        cnt_next   = cnt_reg + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                if (wdb_rdy) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            line_reg       <= '0;
            entry_reg      <= '0;
            txn_reg        <= '0;
            done_vld_reg   <= 1'b0;
            done_entry_reg <= '0;
            done_txn_reg   <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            line_reg     <= line_next;
            done_vld_reg <= wdb_fire;
            err_reg      <= len_err;
            if (first_beat) begin
                entry_reg <= alloc_idx;
                txn_reg   <= in_txn_id;
            end
            if (wdb_fire) begin
                done_entry_reg <= entry_reg;
                done_txn_reg   <= txn_reg;
            end
        end
    end

endmodule

// File: tb/tb_vec_cache_wdb_fill.sv
// Directed bench for vec_cache_wdb_fill: normal fill, backpressure, alloc wait, length errors, mid-line reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_vec_cache_wdb_fill;

    localparam int BW = 256;
    localparam int LW = 1024;
    localparam int EW = 5;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [BW-1:0] in_data;
    logic          in_last;
    logic [TW-1:0] in_txn_id;
    logic          alloc_vld;
    logic          alloc_rdy;
    logic [EW-1:0] alloc_idx;
    logic          wdb_vld;
    logic          wdb_rdy;
    logic [EW-1:0] wdb_entry_id;
    logic [LW-1:0] wdb_data;
    logic          done_vld;
    logic [EW-1:0] done_entry_id;
    logic [TW-1:0] done_txn_id;
    logic          err_pulse;

    int vectors = 0;
    int miscompares = 0;

    vec_cache_wdb_fill #(
        .BEAT_WIDTH(BW), .LINE_WIDTH(LW), .ENTRY_IDX_WIDTH(EW), .TXN_ID_WIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last), .in_txn_id(in_txn_id),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_idx(alloc_idx),
        .wdb_vld(wdb_vld), .wdb_rdy(wdb_rdy), .wdb_entry_id(wdb_entry_id), .wdb_data(wdb_data),
        .done_vld(done_vld), .done_entry_id(done_entry_id), .done_txn_id(done_txn_id),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    // Low 32 bits of each beat, so a line mismatch fits on one short line.
    function automatic logic [127:0] digest(input logic [LW-1:0] d);
        return {d[799:768], d[543:512], d[287:256], d[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_vld = 1'b1; alloc_vld = 1'b1; in_data = rep(8'h55); in_last = 1'b0;
        in_txn_id = 8'h12; alloc_idx = 5'd1; wdb_rdy = 1'b1;
        tick(); tick(); #1;
        vectors++; if (in_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_in_rdy got %b want 0", in_rdy); end
        vectors++; if (alloc_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_alloc_rdy got %b want 0", alloc_rdy); end
        vectors++; if (wdb_vld !== 1'b0) begin miscompares++; $display("FAIL reset_wdb_vld got %b want 0", wdb_vld); end
        vectors++; if (done_vld !== 1'b0) begin miscompares++; $display("FAIL reset_done_vld got %b want 0", done_vld); end
        vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_pulse); end
        vectors++; if (wdb_data !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", digest(wdb_data)); end
        vectors++; if (wdb_entry_id !== '0 || done_entry_id !== '0 || done_txn_id !== '0) begin
            miscompares++; $display("FAIL reset_ids got %h/%h/%h want 0/0/0", wdb_entry_id, done_entry_id, done_txn_id);
        end
        tick();
        rst_n = 1'b1; in_vld = 1'b0; alloc_vld = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [LW-1:0] exp = {rep(8'hA3), rep(8'hA2), rep(8'hA1), rep(8'hA0)};
        tick();
        in_vld = 1'b1; alloc_vld = 1'b1; alloc_idx = 5'd5; in_txn_id = 8'h3C;
        in_data = rep(8'hA0); in_last = 1'b0; wdb_rdy = 1'b1; #1;
        vectors++; if (in_rdy !== 1'b1 || alloc_rdy !== 1'b1) begin
            miscompares++; $display("FAIL basic_first_rdy got %b%b want 11", in_rdy, alloc_rdy);
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            in_data = rep(8'hA0 + 8'(k)); in_last = (k == 3); alloc_vld = 1'b0; in_txn_id = 8'hFF; #1;
            vectors++; if (in_rdy !== 1'b1 || alloc_rdy !== 1'b0 || wdb_vld !== 1'b0) begin
                miscompares++; $display("FAIL basic_fill%0d got rdy=%b alloc=%b wdb=%b want 1 0 0", k, in_rdy, alloc_rdy, wdb_vld);
            end
        end
        tick();
        in_vld = 1'b0; in_last = 1'b0; #1;
        vectors++; if (wdb_vld !== 1'b1 || wdb_entry_id !== 5'd5 || in_rdy !== 1'b0 || err_pulse !== 1'b0) begin
            miscompares++; $display("FAIL basic_write got vld=%b entry=%0d rdy=%b err=%b want 1 5 0 0", wdb_vld, wdb_entry_id, in_rdy, err_pulse);
        end
        vectors++; if (wdb_data !== exp) begin miscompares++; $display("FAIL basic_data got %h want %h", digest(wdb_data), digest(exp)); end
        tick(); #1;
        vectors++; if (done_vld !== 1'b1 || done_entry_id !== 5'd5 || done_txn_id !== 8'h3C || wdb_vld !== 1'b0) begin
            miscompares++; $display("FAIL basic_done got vld=%b entry=%0d txn=%h wdb=%b want 1 5 3c 0", done_vld, done_entry_id, done_txn_id, wdb_vld);
        end
        $display("line entry %0d txn %h written (basic)", done_entry_id, done_txn_id);
        tick(); #1;
        vectors++; if (done_vld !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b want 0", done_vld); end
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] exp = {rep(8'hA3), rep(8'hA2), rep(8'hA1), rep(8'hA0)};
        int dones = 0;
        tick();
        in_vld = 1'b1; alloc_vld = 1'b1; alloc_idx = 5'd6; in_txn_id = 8'h5A;
        in_data = rep(8'hA0); in_last = 1'b0; wdb_rdy = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            in_data = rep(8'hA0 + 8'(k)); in_last = (k == 3); alloc_vld = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            in_vld = 1'b1; alloc_vld = 1'b1; alloc_idx = 5'd20; in_data = rep(8'h77); in_last = 1'b0;
            wdb_rdy = (c == 3); #1;
            if (done_vld === 1'b1) dones++;
            vectors++; if (wdb_vld !== 1'b1 || wdb_entry_id !== 5'd6 || wdb_data !== exp) begin
                miscompares++; $display("FAIL bp_hold%0d got vld=%b entry=%0d data=%h want 1 6 %h", c, wdb_vld, wdb_entry_id, digest(wdb_data), digest(exp));
            end
            vectors++; if (in_rdy !== 1'b0 || alloc_rdy !== 1'b0) begin
                miscompares++; $display("FAIL bp_rdy%0d got %b%b want 00", c, in_rdy, alloc_rdy);
            end
        end
        tick();
        in_vld = 1'b0; alloc_vld = 1'b0; #1;
        if (done_vld === 1'b1) dones++;
        vectors++; if (done_vld !== 1'b1 || done_entry_id !== 5'd6 || done_txn_id !== 8'h5A || wdb_vld !== 1'b0) begin
            miscompares++; $display("FAIL bp_done got vld=%b entry=%0d txn=%h wdb=%b want 1 6 5a 0", done_vld, done_entry_id, done_txn_id, wdb_vld);
        end
        $display("line entry %0d txn %h written (backpressure)", done_entry_id, done_txn_id);
        tick(); #1;
        if (done_vld === 1'b1) dones++;
        vectors++; if (dones != 1 || wdb_vld !== 1'b0) begin
            miscompares++; $display("FAIL bp_single_done got %0d pulses wdb=%b want 1 0", dones, wdb_vld);
        end
    endtask

    task automatic test_wait_alloc();
        logic [LW-1:0] exp = {rep(8'hB3), rep(8'hB2), rep(8'hB1), rep(8'hB0)};
        for (int i = 0; i < 10; i++) begin
            tick();
            in_vld = 1'b1; alloc_vld = 1'b0; alloc_idx = 5'd9; in_txn_id = 8'h11;
            in_data = rep(8'hB0); in_last = 1'b0; wdb_rdy = 1'b1; #1;
            vectors++; if (in_rdy !== 1'b0 || alloc_rdy !== 1'b1 || wdb_vld !== 1'b0) begin
                miscompares++; $display("FAIL wait%0d got rdy=%b alloc=%b wdb=%b want 0 1 0", i, in_rdy, alloc_rdy, wdb_vld);
            end
        end
        tick();
        alloc_vld = 1'b1; #1;
        vectors++; if (in_rdy !== 1'b1) begin miscompares++; $display("FAIL wait_accept got %b want 1", in_rdy); end
        for (int k = 1; k < 4; k++) begin
            tick();
            in_data = rep(8'hB0 + 8'(k)); in_last = (k == 3); alloc_vld = 1'b0; in_txn_id = 8'h00;
        end
        tick();
        in_vld = 1'b0; in_last = 1'b0; #1;
        vectors++; if (wdb_vld !== 1'b1 || wdb_entry_id !== 5'd9 || wdb_data !== exp) begin
            miscompares++; $display("FAIL wait_write got vld=%b entry=%0d data=%h want 1 9 %h", wdb_vld, wdb_entry_id, digest(wdb_data), digest(exp));
        end
        tick(); #1;
        vectors++; if (done_vld !== 1'b1 || done_txn_id !== 8'h11) begin
            miscompares++; $display("FAIL wait_done got vld=%b txn=%h want 1 11", done_vld, done_txn_id);
        end
        $display("line entry %0d txn %h written (alloc wait)", done_entry_id, done_txn_id);
        tick();
    endtask

    task automatic test_early_last();
        logic [LW-1:0] exp = {{(2*BW){1'b0}}, rep(8'hC1), rep(8'hC0)};
        tick();
        in_vld = 1'b1; alloc_vld = 1'b1; alloc_idx = 5'd2; in_txn_id = 8'h22;
        in_data = rep(8'hC0); in_last = 1'b0; wdb_rdy = 1'b1;
        tick();
        in_data = rep(8'hC1); in_last = 1'b1; alloc_vld = 1'b0; #1;
        vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL early_err_pre got %b want 0", err_pulse); end
        tick();
        in_vld = 1'b0; in_last = 1'b0; #1;
        vectors++; if (err_pulse !== 1'b1 || wdb_vld !== 1'b1 || wdb_entry_id !== 5'd2) begin
            miscompares++; $display("FAIL early_err got err=%b vld=%b entry=%0d want 1 1 2", err_pulse, wdb_vld, wdb_entry_id);
        end
        vectors++; if (wdb_data !== exp) begin miscompares++; $display("FAIL early_data got %h want %h", digest(wdb_data), digest(exp)); end
        tick(); #1;
        vectors++; if (err_pulse !== 1'b0 || done_vld !== 1'b1 || done_entry_id !== 5'd2 || done_txn_id !== 8'h22) begin
            miscompares++; $display("FAIL early_done got err=%b done=%b entry=%0d txn=%h want 0 1 2 22", err_pulse, done_vld, done_entry_id, done_txn_id);
        end
        $display("line entry %0d txn %h written (early last)", done_entry_id, done_txn_id);
        tick(); #1;
        vectors++; if (err_pulse !== 1'b0 || done_vld !== 1'b0) begin
            miscompares++; $display("FAIL early_quiet got err=%b done=%b want 0 0", err_pulse, done_vld);
        end
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] exp = {rep(8'hD7), rep(8'hD6), rep(8'hD5), rep(8'hD4)};
        int seen = 0;
        tick();
        in_vld = 1'b1; alloc_vld = 1'b1; alloc_idx = 5'd4; in_txn_id = 8'h44;
        in_data = rep(8'hD0); in_last = 1'b0; wdb_rdy = 1'b1;
        tick();
        in_data = rep(8'hD1); alloc_vld = 1'b0;
        tick();
        alloc_vld = 1'b1; in_data = rep(8'hD2); #1;
        rst_n = 1'b0; #1;
        vectors++; if (in_rdy !== 1'b0 || alloc_rdy !== 1'b0 || wdb_vld !== 1'b0 || done_vld !== 1'b0 || err_pulse !== 1'b0) begin
            miscompares++; $display("FAIL midrst_outs got rdy=%b alloc=%b wdb=%b done=%b err=%b want 0s", in_rdy, alloc_rdy, wdb_vld, done_vld, err_pulse);
        end
        vectors++; if (wdb_data !== '0 || wdb_entry_id !== '0) begin
            miscompares++; $display("FAIL midrst_line got %h entry %0d want 0 0", digest(wdb_data), wdb_entry_id);
        end
        tick();
        rst_n = 1'b1; in_vld = 1'b0; alloc_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wdb_vld === 1'b1 || done_vld === 1'b1) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL midrst_quiet got %0d active cycles want 0", seen); end
        in_vld = 1'b1; alloc_vld = 1'b1; alloc_idx = 5'd7; in_txn_id = 8'h77;
        in_data = rep(8'hD4); in_last = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            in_data = rep(8'hD4 + 8'(k)); in_last = (k == 3); alloc_vld = 1'b0;
        end
        tick();
        in_vld = 1'b0; in_last = 1'b0; #1;
        vectors++; if (wdb_vld !== 1'b1 || wdb_entry_id !== 5'd7 || wdb_data !== exp) begin
            miscompares++; $display("FAIL midrst_next got vld=%b entry=%0d data=%h want 1 7 %h", wdb_vld, wdb_entry_id, digest(wdb_data), digest(exp));
        end
        tick(); #1;
        vectors++; if (done_vld !== 1'b1 || done_entry_id !== 5'd7 || done_txn_id !== 8'h77) begin
            miscompares++; $display("FAIL midrst_done got vld=%b entry=%0d txn=%h want 1 7 77", done_vld, done_entry_id, done_txn_id);
        end
        $display("line entry %0d txn %h written (after reset)", done_entry_id, done_txn_id);
        tick();
    endtask

    task automatic test_no_last();
        logic [LW-1:0] exp1 = {rep(8'hE3), rep(8'hE2), rep(8'hE1), rep(8'hE0)};
        logic [LW-1:0] exp2 = {rep(8'hF3), rep(8'hF2), rep(8'hF1), rep(8'hF0)};
        tick();
        in_vld = 1'b1; alloc_vld = 1'b1; alloc_idx = 5'd3; in_txn_id = 8'h33;
        in_data = rep(8'hE0); in_last = 1'b0; wdb_rdy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            in_data = rep(8'hE0 + 8'(k)); alloc_vld = 1'b0;
        end
        tick();
        in_vld = 1'b1; in_data = rep(8'hF0); alloc_vld = 1'b1; alloc_idx = 5'd12; in_txn_id = 8'h4B; #1;
        vectors++; if (err_pulse !== 1'b1 || wdb_vld !== 1'b1 || wdb_entry_id !== 5'd3 || in_rdy !== 1'b0) begin
            miscompares++; $display("FAIL nolast_write got err=%b vld=%b entry=%0d rdy=%b want 1 1 3 0", err_pulse, wdb_vld, wdb_entry_id, in_rdy);
        end
        vectors++; if (wdb_data !== exp1) begin miscompares++; $display("FAIL nolast_data got %h want %h", digest(wdb_data), digest(exp1)); end
        tick(); #1;
        vectors++; if (done_vld !== 1'b1 || done_entry_id !== 5'd3 || done_txn_id !== 8'h33 || err_pulse !== 1'b0 || in_rdy !== 1'b1) begin
            miscompares++; $display("FAIL nolast_done got done=%b entry=%0d txn=%h err=%b rdy=%b want 1 3 33 0 1", done_vld, done_entry_id, done_txn_id, err_pulse, in_rdy);
        end
        $display("line entry %0d txn %h written (no last)", done_entry_id, done_txn_id);
        for (int k = 1; k < 4; k++) begin
            tick();
            in_data = rep(8'hF0 + 8'(k)); in_last = (k == 3); alloc_vld = 1'b0;
        end
        tick();
        in_vld = 1'b0; in_last = 1'b0; #1;
        vectors++; if (wdb_vld !== 1'b1 || wdb_entry_id !== 5'd12 || wdb_data !== exp2 || err_pulse !== 1'b0) begin
            miscompares++; $display("FAIL nolast_next got vld=%b entry=%0d data=%h err=%b want 1 12 %h 0", wdb_vld, wdb_entry_id, digest(wdb_data), err_pulse, digest(exp2));
        end
        tick(); #1;
        vectors++; if (done_vld !== 1'b1 || done_entry_id !== 5'd12 || done_txn_id !== 8'h4B) begin
            miscompares++; $display("FAIL nolast_done2 got vld=%b entry=%0d txn=%h want 1 12 4b", done_vld, done_entry_id, done_txn_id);
        end
        $display("line entry %0d txn %h written (next line)", done_entry_id, done_txn_id);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wait_alloc();
        test_early_last();
        test_reset_mid();
        test_no_last();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
